// File: rtl/tcp_hdr_pkg.sv
// Shared types and field positions for the TCP/IPv4 header checksum stage.
// Bit positions refer to the 432-bit Ethernet/IPv4/TCP header (bit 431 = first byte MSB).
package tcp_hdr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IP_SUM,
    IP_FIN,
    TCP_SUM,
    TCP_FIN,
    OUT
  } state_e;

  localparam int unsigned HDR_W = 432;

  localparam int unsigned IP_LEN_HI   = 303;
  localparam int unsigned IP_LEN_LO   = 288;
  localparam int unsigned IP_CSUM_HI  = 239;
  localparam int unsigned IP_CSUM_LO  = 224;
  localparam int unsigned IP_SRC_HI   = 223;
  localparam int unsigned IP_SRC_LO   = 192;
  localparam int unsigned IP_DST_HI   = 191;
  localparam int unsigned IP_DST_LO   = 160;
  localparam int unsigned TCP_OFF_HI  = 63;
  localparam int unsigned TCP_OFF_LO  = 60;
  localparam int unsigned TCP_CSUM_HI = 47;
  localparam int unsigned TCP_CSUM_LO = 32;

  localparam logic [15:0] IP_PROTO_TCP = 16'h0006;
  localparam logic [3:0]  TCP_DATA_OFF = 4'h5;

  // LSB of the word selected when the counter is zero; later words sit 16*cnt lower.
  localparam logic [8:0] IP_WORD_BASE  = 9'd304;  // [319:304]
  localparam logic [8:0] PSEUDO_BASE   = 9'd208;  // [223:208], IP src/dst words
  // TCP header words use cnt 6..15, so the base is offset by 6 words: 144 + 96.
  localparam logic [8:0] TCP_WORD_BASE = 9'd240;

  localparam logic [3:0] IP_LAST  = 4'd9;
  localparam logic [3:0] TCP_LAST = 4'd15;

endpackage

// File: rtl/ones_comp_acc.sv
// 16-bit ones'-complement accumulator with end-around carry.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         zero the accumulator (wins over add_en)
//   add_en        add word_in this cycle
//   word_in       16-bit word to add
//   sum_out       inverted, carry-folded sum (checksum field value)
module ones_comp_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add_en,
  input  logic [15:0] word_in,
  output logic [15:0] sum_out
);

  // Bit 16 holds the pending end-around carry, folded in on the next add.
  logic [16:0] acc_q, acc_d;
  logic [15:0] folded;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = {1'b0, acc_q[15:0]} + {1'b0, word_in} + {16'b0, acc_q[16]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // acc_q never reaches 17'h1ffff from a cleared start, so this fold cannot overflow.
  always_comb begin
    folded  = acc_q[15:0] + {15'b0, acc_q[16]};
    sum_out = ~folded;
  end

endmodule

// File: rtl/tcp_hdr_checksum.sv
// Fills ip_len and the TCP data offset, then computes the IPv4 header checksum and the
// TCP checksum (pseudo-header + 20-byte header, no payload) one 16-bit word per cycle.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   hdr_in      432-bit header from the builder
//   hdr_ready   one-cycle pulse, hdr_in valid (honoured only when idle)
//   busy        high whenever not idle
//   hdr_out     completed header, held while out_valid
//   out_valid   hdr_out valid
//   out_ready   downstream accepts
module tcp_hdr_checksum
  import tcp_hdr_pkg::*;
#(
  parameter logic [15:0] IP_TOTAL_LEN = 16'h0028,
  parameter logic [15:0] TCP_SEG_LEN  = 16'h0014
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [HDR_W-1:0]   hdr_in,
  input  logic               hdr_ready,
  output logic               busy,
  output logic [HDR_W-1:0]   hdr_out,
  output logic               out_valid,
  input  logic               out_ready
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [HDR_W-1:0]   work_q, work_d;
  logic [HDR_W-1:0]   hdr_out_q, hdr_out_d;
  logic               out_valid_q, out_valid_d;

  logic               acc_clear, acc_add;
  logic [8:0]         base;
  logic [15:0]        word, csum;

  ones_comp_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc_clear),
    .add_en  (acc_add),
    .word_in (word),
    .sum_out (csum)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hdr_ready) state_d = IP_SUM;
      IP_SUM:  if (cnt_q == IP_LAST) state_d = IP_FIN;
      IP_FIN:  state_d = TCP_SUM;
      TCP_SUM: if (cnt_q == TCP_LAST) state_d = TCP_FIN;
      TCP_FIN: state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake, accumulator control and word select
  always_comb begin
    busy      = (state_q != IDLE);
    acc_clear = ((state_q == IDLE) && hdr_ready) || (state_q == IP_FIN);
    acc_add   = (state_q == IP_SUM) || (state_q == TCP_SUM);
    base      = '0;
    word      = '0;
    unique case (state_q)
      IP_SUM: begin
        base = IP_WORD_BASE - {1'b0, cnt_q, 4'b0000};
        word = work_q[base +: 16];
      end
      TCP_SUM: begin
        if (cnt_q < 4'd4) begin
          base = PSEUDO_BASE - {1'b0, cnt_q, 4'b0000};
          word = work_q[base +: 16];
        end else if (cnt_q == 4'd4) begin
          word = IP_PROTO_TCP;
        end else if (cnt_q == 4'd5) begin
          word = TCP_SEG_LEN;
        end else begin
          base = TCP_WORD_BASE - {1'b0, cnt_q, 4'b0000};
          word = work_q[base +: 16];
        end
      end
      default: ;
    endcase
  end

  // Datapath next state
  always_comb begin
    work_d      = work_q;
    cnt_d       = cnt_q;
    hdr_out_d   = hdr_out_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (hdr_ready) begin
          work_d = hdr_in;
          work_d[IP_LEN_HI:IP_LEN_LO]     = IP_TOTAL_LEN;
          work_d[IP_CSUM_HI:IP_CSUM_LO]   = '0;
          work_d[TCP_OFF_HI:TCP_OFF_LO]   = TCP_DATA_OFF;
          work_d[TCP_CSUM_HI:TCP_CSUM_LO] = '0;
          cnt_d = '0;
        end
      end
      IP_SUM:  cnt_d = (cnt_q == IP_LAST) ? 4'd0 : cnt_q + 4'd1;
      IP_FIN:  work_d[IP_CSUM_HI:IP_CSUM_LO] = csum;
      TCP_SUM: cnt_d = cnt_q + 4'd1;  // wraps to 0 after the 16th word
      TCP_FIN: begin
        work_d[TCP_CSUM_HI:TCP_CSUM_LO] = csum;
        hdr_out_d   = work_d;
        out_valid_d = 1'b1;
      end
      OUT:     if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      work_q      <= '0;
      hdr_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      hdr_out_q   <= hdr_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign hdr_out   = hdr_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tcp_hdr_checksum.sv
// Directed bench for tcp_hdr_checksum: nominal, backpressure, back-to-back,
// mid-operation reset and carry-wrap headers.
module tb_tcp_hdr_checksum;

  logic         clk = 1'b0;
  logic         rst;
  logic [431:0] hdr_in;
  logic         hdr_ready;
  logic         busy;
  logic [431:0] hdr_out;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  tcp_hdr_checksum dut (
    .clk       (clk),
    .rst       (rst),
    .hdr_in    (hdr_in),
    .hdr_ready (hdr_ready),
    .busy      (busy),
    .hdr_out   (hdr_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [431:0] mk_hdr(input logic [15:0] id, input logic [31:0] sip,
                                          input logic [31:0] dip, input logic [15:0] sp,
                                          input logic [15:0] dp, input logic [15:0] ipcs,
                                          input logic [15:0] tcs, input logic [15:0] iplen,
                                          input logic [3:0] off);
    logic [431:0] h;
    h = '0;
    h[431:384] = 48'h001122334455;
    h[383:336] = 48'h66778899aabb;
    h[335:320] = 16'h0800;
    h[319:304] = 16'h4510;
    h[303:288] = iplen;
    h[287:272] = id;
    h[271:256] = 16'h4000;
    h[255:248] = 8'h40;
    h[247:240] = 8'h06;
    h[239:224] = ipcs;
    h[223:192] = sip;
    h[191:160] = dip;
    h[159:144] = sp;
    h[143:128] = dp;
    h[127:96]  = 32'h0000_0001;
    h[95:64]   = 32'h0;
    h[63:60]   = off;
    h[56:48]   = 9'h002;
    h[47:32]   = tcs;
    h[31:16]   = 16'h3908;
    h[15:0]    = 16'h0;
    return h;
  endfunction

  function automatic logic [15:0] fold_inv(input logic [31:0] s_in);
    logic [31:0] s;
    s = s_in;
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  // Reference: plain integer sum of all words, folded at the end.
  function automatic logic [431:0] exp_hdr(input logic [431:0] h);
    logic [431:0] e;
    logic [31:0]  s;
    e = h;
    e[303:288] = 16'h0028;
    e[239:224] = 16'h0;
    e[63:60]   = 4'h5;
    e[47:32]   = 16'h0;
    s = 32'h0;
    for (int i = 0; i < 10; i++) s = s + {16'h0, e[319 - 16*i -: 16]};
    e[239:224] = fold_inv(s);
    s = {16'h0, e[223:208]} + {16'h0, e[207:192]} + {16'h0, e[191:176]}
      + {16'h0, e[175:160]} + 32'h0006 + 32'h0014;
    for (int i = 0; i < 10; i++) s = s + {16'h0, e[159 - 16*i -: 16]};
    e[47:32] = fold_inv(s);
    return e;
  endfunction

  task automatic check(input string tag, input logic [431:0] obs, input logic [431:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [431:0] h);
    hdr_in    = h;
    hdr_ready = 1'b1;
    tick();
    hdr_ready = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  logic [431:0] h_nom, h_b2b, h_wrap, held;
  int n, bad, seen;

  initial begin
    h_nom  = mk_hdr(16'h0000, 32'hc0a80001, 32'hc0a80002, 16'h0050, 16'h1234,
                    16'h0000, 16'h0000, 16'h0000, 4'h0);
    // id chosen so the IP words sum to 0xffff: checksum field must read 0x0000
    h_b2b  = mk_hdr(16'hb96c, 32'hc0a80001, 32'hc0a80002, 16'h0050, 16'h1234,
                    16'h0000, 16'h0000, 16'h0028, 4'h5);
    h_wrap = mk_hdr(16'h0000, 32'hffffffff, 32'hffffffff, 16'hffff, 16'hffff,
                    16'habcd, 16'h1357, 16'h0000, 4'h0);

    rst = 1'b0; hdr_in = '0; hdr_ready = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_busy", 432'(busy), 432'(0));
    check("rst_valid", 432'(out_valid), 432'(0));
    check("rst_hdr_out", hdr_out, '0);
    rst = 1'b1;
    tick();

    // Nominal
    out_ready = 1'b1;
    send(h_nom);
    check("nom_busy", 432'(busy), 432'(1));
    wait_valid(n);
    check("nom_latency", 432'(n), 432'(28));
    check("nom_ip_len", 432'(hdr_out[303:288]), 432'(16'h0028));
    check("nom_ip_csum", 432'(hdr_out[239:224]), 432'(16'hb96c));
    check("nom_tcp_csum", 432'(hdr_out[47:32]), 432'(16'he301));
    check("nom_data_off", 432'(hdr_out[63:60]), 432'(4'h5));
    check("nom_hdr", hdr_out, exp_hdr(h_nom));
    tick();
    check("nom_valid_drop", 432'(out_valid), 432'(0));
    check("nom_idle", 432'(busy), 432'(0));

    // Backpressure
    out_ready = 1'b0;
    send(h_nom);
    wait_valid(n);
    check("bp_latency", 432'(n), 432'(28));
    check("bp_hdr", hdr_out, exp_hdr(h_nom));
    held = hdr_out;
    bad  = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (hdr_out !== held || out_valid !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("bp_stable", 432'(bad), 432'(0));
    out_ready = 1'b1;
    tick();
    check("bp_xfer_valid", 432'(out_valid), 432'(0));
    check("bp_xfer_idle", 432'(busy), 432'(0));

    // Back-to-back, with a stray hdr_ready during computation
    send(h_nom);
    tick(); tick(); tick(); tick();
    hdr_in = h_b2b; hdr_ready = 1'b1;
    tick();
    hdr_ready = 1'b0; hdr_in = '0;
    wait_valid(n);
    check("b2b_stray_latency", 432'(n), 432'(23));
    check("b2b_first_hdr", hdr_out, exp_hdr(h_nom));
    tick();
    send(h_b2b);
    check("b2b_captured", 432'(busy), 432'(1));
    wait_valid(n);
    check("b2b_latency", 432'(n), 432'(28));
    check("b2b_zero_csum", 432'(hdr_out[239:224]), 432'(16'h0000));
    check("b2b_second_hdr", hdr_out, exp_hdr(h_b2b));
    tick();

    // Reset mid-operation
    out_ready = 1'b0;
    send(h_nom);
    for (int i = 0; i < 12; i++) tick();
    rst = 1'b0;
    #1;
    check("mrst_busy", 432'(busy), 432'(0));
    check("mrst_valid", 432'(out_valid), 432'(0));
    check("mrst_hdr_out", hdr_out, '0);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("mrst_quiet", 432'(seen), 432'(0));

    // Carry wrap with pre-filled checksum fields
    out_ready = 1'b1;
    send(h_wrap);
    wait_valid(n);
    check("wrap_latency", 432'(n), 432'(28));
    check("wrap_ip_csum", 432'(hdr_out[239:224]), 432'(16'h3ac1));
    check("wrap_tcp_csum", 432'(hdr_out[47:32]), 432'(16'h76da));
    check("wrap_hdr", hdr_out, exp_hdr(h_wrap));
    tick();
    check("wrap_valid_drop", 432'(out_valid), 432'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_hdr_checksum.md
Name: tcp_hdr_checksum

Overview:
- Sits directly downstream of the packet header builder and consumes its 432-bit Ethernet/IPv4/TCP header, delivered with a ready/busy handshake.
- Fills ip_len, forces the TCP data offset, and computes both the IPv4 header checksum and the TCP checksum (pseudo-header plus 20-byte TCP header, no payload).
- Presents the finished header to the MAC/serializer stage on a valid/ready handshake.

Parameters:
- IP_TOTAL_LEN, 16'h0028, value written into ip_len (20 B IP + 20 B TCP).
- TCP_SEG_LEN, 16'h0014, TCP length used in the pseudo-header.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- hdr_in  in  432  header from the builder; bit layout identical to the builder output.
- hdr_ready  in  1  one-cycle pulse: hdr_in is valid.
- busy  out  1  high whenever the block is not IDLE; the builder stalls on it.
- hdr_out  out  432  completed header.
- out_valid  out  1  hdr_out is valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset (rst low, async): state=IDLE, busy=0, out_valid=0, hdr_out=0, accumulator=0, word index=0.
- busy is combinational: busy = (state != IDLE).
- Capture: on an edge with state==IDLE and hdr_ready=1, latch hdr_in into the working register with the following overrides:
  - [303:288]=IP_TOTAL_LEN
  - [239:224]=0
  - [63:60]=4'h5
  - [47:32]=0
  - Clear the accumulator and enter IP_SUM.
- hdr_ready while busy is ignored; the upstream protocol prevents it.
- IP_SUM (10 cycles): add one 16-bit word per cycle, from [319:304] down to [175:160], into a 17-bit ones'-complement accumulator with end-around carry (acc = acc[15:0] + word + acc[16]).
- IP_FIN (1 cycle): fold the carry, write the inverted result to [239:224], clear the accumulator.
- TCP_SUM (16 cycles), word order:
  - [223:208], [207:192], [191:176], [175:160]
  - 16'h0006
  - TCP_SEG_LEN
  - [159:144] down to [15:0] (10 words)
- TCP_FIN (1 cycle): fold, write the inverted result to [47:32], load hdr_out from the working register, set out_valid=1, enter OUT.
- Latency: out_valid rises on the 28th rising edge after the capture edge (fixed, data independent).
- OUT: hdr_out and out_valid are held stable until out_ready=1. On the transfer edge: out_valid<=0, state<=IDLE. A new capture is possible on the following edge.
- out_ready ignored when out_valid=0.
- Checksum field rule: a computed 0x0000 is written as-is (no 0xFFFF substitution for a zero result).
- No other header bits are modified; MAC, eth_type, ports, seq, ack, flags, window and urgent fields pass through unchanged.
- Reset mid-operation aborts the packet; the partial header is discarded and out_valid stays 0.

Decomposition:
- Package tcp_hdr_pkg: state enum (IDLE, IP_SUM, IP_FIN, TCP_SUM, TCP_FIN, OUT); localparams for field bit positions (IP_LEN_HI/LO, IP_CSUM_HI/LO, TCP_OFF_HI/LO, TCP_CSUM_HI/LO, IP_SRC, IP_DST); IP_PROTO_TCP=16'h0006.
- Sub-module ones_comp_acc: 16-bit ones'-complement accumulator with clear, add_en, word_in, and folded inverted sum_out. Instantiated once and reused for both checksums.
- Word selection is a combinational mux indexed by state and a 4-bit counter.

Test Plan:
- Common stimulus for the first three scenarios: header with tos 0x10, flags 3'b010, ttl 0x40, proto 0x06, src IP C0A80001, dst IP C0A80002, [159:144]=0x0050, [143:128]=0x1234, seq 0x00000001, ack 0, flags 9'h002, window 0x3908, urgent 0.
- Nominal: pulse hdr_ready with the common stimulus and hold out_ready=1. Required: ip_len 0x0028, IP checksum 0xB96C, TCP checksum 0xE301, data offset 5, out_valid exactly 28 edges after capture.
- Backpressure: same stimulus, out_ready=0 for 50 cycles. Required: hdr_out and out_valid stable and busy=1 throughout; transfer completes one edge after out_ready rises.
- Back-to-back: second hdr_ready pulsed on the edge after the first transfer. Required: captured; second result correct. A hdr_ready pulsed mid-computation is ignored and the first result is unchanged.
- Reset mid-operation: assert rst at cycle 12 after capture. Required: outputs clear immediately (async); after release, busy=0 and no out_valid.
- Carry wrap: all-FFFF IPs and ports plus pre-filled nonzero checksum fields. Required: sums match a bench ones'-complement model and pre-filled checksum values are ignored.
